// File: rtl/inv_srows_seq.sv
// rtl/inv_srows_seq.sv - AES inverse ShiftRows with valid/ready handshake, one row per clock or all at once
//
// Ports:
//   clk         rising-edge clock for all state
//   rst         synchronous active-high reset
//   in_valid    producer offers a state on in_data
//   in_ready    high only in IDLE; acceptance = in_valid & in_ready
//   in_data     128-bit AES state, byte k at [127-8k -: 8], row k%4, column k/4
//   out_valid   high only in DONE; out_data holds the finished result
//   out_ready   consumer takes out_data; only meaningful in DONE
//   out_data    working register (result when out_valid=1, 0 after reset)
//   busy        high in any state other than IDLE
//   done_count  number of completed handoffs, saturating at 16'hFFFF
//
// Parameter ONE_CYCLE: 0 rotates rows 1..3 on successive clocks (SH1..SH3),
// 1 loads the fully inverse-shifted state on acceptance and goes straight to DONE.

module inv_srows_seq #(
    parameter bit ONE_CYCLE = 1'b0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy,
    output logic [15:0]  done_count
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        SH1  = 3'd1,
        SH2  = 3'd2,
        SH3  = 3'd3,
        DONE = 3'd4
    } state_t;

    state_t       state;
    state_t       state_nx;
    logic [127:0] work;
    logic [127:0] work_nx;
    logic         handoff;

    // Rotate row r of state s right by r columns: result(r,c) = s(r,(c-r) mod 4).
    // Other rows pass through untouched.
    function automatic logic [127:0] rot_row(input logic [127:0] s, input int r);
        logic [127:0] t;
        t = s;
        for (int c = 0; c < 4; c++) begin
            t[127 - 8*(4*c + r) -: 8] = s[127 - 8*(4*((c - r + 4) % 4) + r) -: 8];
        end
        return t;
    endfunction

    function automatic logic [127:0] inv_full(input logic [127:0] s);
        return rot_row(rot_row(rot_row(s, 1), 2), 3);
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            work  <= '0;
        end else begin
            state <= state_nx;
            work  <= work_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        work_nx   = work;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        handoff   = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    if (ONE_CYCLE) begin
                        work_nx  = inv_full(in_data);
                        state_nx = DONE;
                    end else begin
                        work_nx  = in_data;
                        state_nx = SH1;
                    end
                end
            end
            SH1: begin
                work_nx  = rot_row(work, 1);
                state_nx = SH2;
            end
            SH2: begin
                work_nx  = rot_row(work, 2);
                state_nx = SH3;
            end
            SH3: begin
                work_nx  = rot_row(work, 3);
                state_nx = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    handoff  = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            done_count <= '0;
        end else if (handoff && (done_count != 16'hFFFF)) begin
            done_count <= done_count + 16'd1;
        end
    end

    assign busy     = (state != IDLE);
    assign out_data = work;

endmodule

// File: tb/tb_inv_srows_seq.sv
// tb/tb_inv_srows_seq.sv - scoreboard bench for inv_srows_seq, both ONE_CYCLE settings
module tb_inv_srows_seq;

    localparam logic [127:0] VEC     = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] VEC_EXP = 128'h000d0a0704010e0b0805020f0c090603;

    logic         clk;
    logic         rst0, rst1;
    logic         in_valid0, in_ready0, out_valid0, out_ready0, busy0;
    logic         in_valid1, in_ready1, out_valid1, out_ready1, busy1;
    logic [127:0] in_data0, out_data0, in_data1, out_data1;
    logic [15:0]  done_count0, done_count1;

    int           checks = 0;
    int           failures = 0;
    logic [127:0] q0[$];
    logic [127:0] q1[$];
    logic         rt_mode = 1'b0;
    logic [127:0] rt_orig = '0;

    inv_srows_seq #(.ONE_CYCLE(1'b0)) u0 (
        .clk(clk), .rst(rst0),
        .in_valid(in_valid0), .in_ready(in_ready0), .in_data(in_data0),
        .out_valid(out_valid0), .out_ready(out_ready0), .out_data(out_data0),
        .busy(busy0), .done_count(done_count0)
    );

    inv_srows_seq #(.ONE_CYCLE(1'b1)) u1 (
        .clk(clk), .rst(rst1),
        .in_valid(in_valid1), .in_ready(in_ready1), .in_data(in_data1),
        .out_valid(out_valid1), .out_ready(out_ready1), .out_data(out_data1),
        .busy(busy1), .done_count(done_count1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: result byte at (r,c) comes from source byte (r,(c-r) mod 4).
    function automatic logic [127:0] inv_model(input logic [127:0] s);
        logic [127:0] res;
        int r, c, src;
        res = '0;
        for (int k = 0; k < 16; k++) begin
            r   = k % 4;
            c   = k / 4;
            src = 4 * ((c + 4 - r) % 4) + r;
            res[127 - 8*k -: 8] = s[127 - 8*src -: 8];
        end
        return res;
    endfunction

    // Forward ShiftRows: result(r,c) = source(r,(c+r) mod 4).
    function automatic logic [127:0] fwd_model(input logic [127:0] s);
        logic [127:0] res;
        int r, c, src;
        res = '0;
        for (int k = 0; k < 16; k++) begin
            r   = k % 4;
            c   = k / 4;
            src = 4 * ((c + r) % 4) + r;
            res[127 - 8*k -: 8] = s[127 - 8*src -: 8];
        end
        return res;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Scoreboards: push on acceptance, pop and compare on handoff, flush on reset.
    always @(negedge clk) begin
        if (rst0) begin
            q0.delete();
        end else begin
            if (in_valid0 && in_ready0)
                q0.push_back(rt_mode ? rt_orig : inv_model(in_data0));
            if (out_valid0 && out_ready0) begin
                checks++;
                assert (q0.size() > 0) else begin
                    failures++;
                    $error("FAIL sb0_unexpected_out observed=%h expected=no_output", out_data0);
                end
                if (q0.size() > 0) chk("sb0_data", out_data0, q0.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (rst1) begin
            q1.delete();
        end else begin
            if (in_valid1 && in_ready1)
                q1.push_back(inv_model(in_data1));
            if (out_valid1 && out_ready1) begin
                checks++;
                assert (q1.size() > 0) else begin
                    failures++;
                    $error("FAIL sb1_unexpected_out observed=%h expected=no_output", out_data1);
                end
                if (q1.size() > 0) chk("sb1_data", out_data1, q1.pop_front());
            end
        end
    end

    initial begin
        logic [127:0] orig;
        logic         got;

        rst0 = 1'b1; rst1 = 1'b1;
        in_valid0 = 1'b0; in_data0 = '0; out_ready0 = 1'b0;
        in_valid1 = 1'b0; in_data1 = '0; out_ready1 = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid0", 128'(out_valid0), 128'(1'b0));
        chk("rst_busy0",      128'(busy0),      128'(1'b0));
        chk("rst_in_ready0",  128'(in_ready0),  128'(1'b1));
        chk("rst_out_data0",  out_data0,        128'h0);
        chk("rst_count0",     128'(done_count0), 128'h0);
        chk("rst_out_valid1", 128'(out_valid1), 128'(1'b0));
        chk("rst_in_ready1",  128'(in_ready1),  128'(1'b1));
        chk("rst_out_data1",  out_data1,        128'h0);
        @(posedge clk); #1;
        rst0 = 1'b0; rst1 = 1'b0;

        // Reset in SH2 discards the in-flight state; out_ready outside DONE is harmless
        in_data0 = VEC; in_valid0 = 1'b1; out_ready0 = 1'b1;
        @(posedge clk); #1;
        in_valid0 = 1'b0;
        @(negedge clk);
        chk("mid_busy_sh1", 128'(busy0), 128'(1'b1));
        @(posedge clk); #1;
        rst0 = 1'b1;
        @(posedge clk); #1;
        rst0 = 1'b0;
        @(negedge clk);
        chk("mid_out_valid", 128'(out_valid0), 128'(1'b0));
        chk("mid_busy",      128'(busy0),      128'(1'b0));
        chk("mid_in_ready",  128'(in_ready0),  128'(1'b1));
        chk("mid_out_data",  out_data0,        128'h0);
        chk("mid_count",     128'(done_count0), 128'h0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("mid_no_pulse", 128'(out_valid0), 128'(1'b0));
        end
        out_ready0 = 1'b0;

        // Basic vector, 4-cycle latency, in_data changes after acceptance
        in_data0 = VEC; in_valid0 = 1'b1;
        @(posedge clk); #1;
        in_valid0 = 1'b0;
        in_data0  = rnd128();
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            chk("lat_out_valid", 128'(out_valid0), 128'(i == 4));
        end
        chk("basic_out_data", out_data0, VEC_EXP);
        chk("basic_count0",   128'(done_count0), 128'h0);

        // Backpressure with in_valid asserted in DONE (must be ignored)
        in_valid0 = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            in_data0 = rnd128();
            @(negedge clk);
            chk("bp_out_valid", 128'(out_valid0), 128'(1'b1));
            chk("bp_out_data",  out_data0,        VEC_EXP);
            chk("bp_in_ready",  128'(in_ready0),  128'(1'b0));
        end

        // Handoff with in_valid high: accepted only in the following IDLE cycle
        in_data0 = rnd128();
        out_ready0 = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("ho_out_valid", 128'(out_valid0), 128'(1'b0));
        chk("ho_in_ready",  128'(in_ready0),  128'(1'b1));
        chk("ho_count",     128'(done_count0), 128'h1);
        @(posedge clk); #1;
        for (int j = 0; j < 3; j++) begin
            in_data0 = rnd128();
            @(negedge clk);
            chk("stab_in_ready", 128'(in_ready0), 128'(1'b0));
            @(posedge clk); #1;
        end
        in_valid0 = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (q0.size() == 0) break;
        end
        repeat (3) @(negedge clk);
        chk("stab_drain", 128'(q0.size()), 128'h0);
        chk("stab_count", 128'(done_count0), 128'h2);

        // ONE_CYCLE=1 back-to-back: one result every 2 cycles
        in_data1 = rnd128(); in_valid1 = 1'b1; out_ready1 = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            in_data1 = rnd128();
            @(negedge clk);
            chk("b2b_out_valid", 128'(out_valid1), 128'(i % 2 == 0));
        end
        in_valid1 = 1'b0;
        repeat (3) @(negedge clk);
        chk("b2b_count", 128'(done_count1), 128'd10);
        chk("b2b_drain", 128'(q1.size()), 128'h0);

        // Round trip: forward ShiftRows model, then the block, equals the original
        @(posedge clk); #1;
        rst0 = 1'b1;
        @(posedge clk); #1;
        rst0 = 1'b0;
        rt_mode = 1'b1;
        out_ready0 = 1'b1;
        for (int n = 0; n < 1000; n++) begin
            orig      = rnd128();
            rt_orig   = orig;
            in_data0  = fwd_model(orig);
            in_valid0 = 1'b1;
            got = 1'b0;
            for (int k = 0; k < 20; k++) begin
                @(negedge clk);
                if (in_ready0) begin
                    @(posedge clk); #1;
                    got = 1'b1;
                    break;
                end
            end
            chk("rt_accept", 128'(got), 128'(1'b1));
            if (!got) break;
        end
        in_valid0 = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (q0.size() == 0) break;
        end
        repeat (3) @(negedge clk);
        chk("rt_drain", 128'(q0.size()), 128'h0);
        chk("rt_count", 128'(done_count0), 128'd1000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/inv_srows_seq.md
INV_SROWS_SEQ -- requirements
Module: inv_srows_seq

Interface
REQ-001 Parameter ONE_CYCLE, default 0; 0 = one row rotated per clock, 1 = all rows rotated in the acceptance cycle.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 in_valid  input  1  producer has a 128-bit state on in_data.
REQ-005 in_ready  output  1  block can accept a state this cycle.
REQ-006 in_data  input  128  AES state to inverse-shift.
REQ-007 out_valid  output  1  out_data holds a completed result.
REQ-008 out_ready  input  1  consumer accepts out_data this cycle.
REQ-009 out_data  output  128  working or result state, meaningful only while out_valid=1.
REQ-010 busy  output  1  high in any state other than IDLE.
REQ-011 done_count  output  16  count of results handed off, saturating at 0xFFFF.

Function
REQ-012 Byte k (k=0..15) occupies bits [127-8k:120-8k] and maps to row r=k mod 4, column c=k/4.
REQ-013 The inverse row shift SHALL give result(r,c) = source(r,(c-r) mod 4), i.e. row r rotated right by r columns; row 0 is unchanged.
REQ-014 FSM states SHALL be IDLE, SH1, SH2, SH3 and DONE.
REQ-015 in_ready SHALL be 1 only in IDLE; acceptance = in_valid & in_ready.
REQ-016 On acceptance with ONE_CYCLE=0, in_data SHALL be loaded into the working register and the FSM SHALL enter SH1.
REQ-017 SH1 rotates row 1, SH2 rotates row 2 and SH3 rotates row 3 of the working register, one edge each; transitions are SH1->SH2->SH3->DONE.
REQ-018 With ONE_CYCLE=1, acceptance SHALL load the fully inverse-shifted state and go IDLE->DONE; SH1..SH3 are unreachable.
REQ-019 Latency from the acceptance edge to out_valid=1 SHALL be 4 cycles for ONE_CYCLE=0 and 1 cycle for ONE_CYCLE=1.
REQ-020 out_valid SHALL be 1 exactly in DONE.
REQ-021 In DONE, out_data SHALL stay stable until out_ready=1; DONE with out_ready=1 SHALL go to IDLE on the next edge.
REQ-022 Each DONE-and-out_ready handoff SHALL increment done_count by 1, holding at 0xFFFF.
REQ-023 in_data changes after acceptance SHALL not affect the result.
REQ-024 in_valid asserted outside IDLE SHALL be ignored (no acceptance, no state change).
REQ-025 in_valid=1 in the cycle DONE hands off SHALL not be accepted until the following IDLE cycle; maximum throughput is one result per 5 cycles (ONE_CYCLE=0) or per 2 cycles (ONE_CYCLE=1).
REQ-026 out_ready=1 outside DONE SHALL have no effect.

Reset
REQ-027 rst=1 at a rising edge SHALL force state=IDLE, working register=0, done_count=0.
REQ-028 Output values while in reset: out_valid=0, busy=0, in_ready=1 from the first post-reset cycle, out_data=0.
REQ-029 rst asserted in any of SH1..SH3 or DONE SHALL discard the in-flight state and produce no handoff.
REQ-030 rst SHALL take priority over acceptance and handoff in the same cycle.

Verification
REQ-031 Basic vector (ONE_CYCLE=0): accept in_data=0x000102030405060708090a0b0c0d0e0f -> out_valid=1 exactly 4 cycles later, out_data=0x000d0a0704010e0b0805020f0c090603, done_count 0->1 on handoff.
REQ-032 Backpressure: hold out_ready=0 for 10 cycles in DONE -> out_valid stays 1, out_data unchanged, in_ready=0; out_ready=1 -> IDLE next cycle.
REQ-033 Input stability: change in_data every cycle after acceptance and keep in_valid=1 -> result matches the accepted value only, and no second acceptance before IDLE.
REQ-034 Reset mid-op: assert rst in SH2 -> next cycle IDLE, out_valid=0, out_data=0, done_count unchanged from 0, no out_valid pulse.
REQ-035 ONE_CYCLE=1 back-to-back with in_valid and out_ready held high -> results every 2 cycles, each equal to the inverse row shift of its input.
REQ-036 Round trip: 1000 random states through the existing forward ShiftRows model then this block -> output equals the original state; done_count=1000.
